cpu_mem_responder: RTL and testbench

//  Memory-side responder for the CPU's data-memory bus (addr/data/we out of the CPU, mem back into it).

---
 rtl/cpu_mem_responder.sv | 147 ++++++++++++++
 tb/tb_cpu_mem_responder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_responder.sv
// ---------------------------------------------------------------------------
// cpu_mem_responder
//
// Memory-side responder for the CPU data-memory bus. Owns a
// 2**ADDR_WIDTH x DATA_WIDTH RAM and steps through three phases:
//   S_CLEAR : zero-fill every word, one word per cycle (2**ADDR_WIDTH cycles)
//   S_LOAD  : accept a program image on the loader port
//   S_RUN   : release the CPU (cpu_run=1) and serve its reads and writes
//
// Loader handshake: a word transfers on a rising edge where
// ld_valid && ld_ready. ld_ready is high for the whole of S_LOAD, so the
// loader never waits; ld_valid low is simply an idle cycle. A transfer with
// ld_last set moves the block to S_RUN on that same edge.
//
// Optional feature (macro MEM_WP_EN): in S_RUN, CPU writes below PROG_START
// are dropped and the sticky output wp_err reports that one happened.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   addr, data, we    CPU word address, write data, write enable
//   mem               CPU read data (combinational from addr in S_RUN, else 0)
//   ld_valid/ld_ready loader handshake
//   ld_addr, ld_data  loader target address and word
//   ld_last           marks the final loader word
//   cpu_run           registered, 1 in S_RUN (drives the CPU's rst_n)
//   busy              registered, 1 in S_CLEAR / S_LOAD
//   wp_err            (MEM_WP_EN only) sticky dropped-write flag
// ---------------------------------------------------------------------------
module cpu_mem_responder #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int PROG_START = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  we,
  output logic [DATA_WIDTH-1:0] mem,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_last,
  output logic                  cpu_run,
`ifdef MEM_WP_EN
  output logic                  busy,
  output logic                  wp_err
`else
  output logic                  busy
`endif
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

`ifdef MEM_WP_EN
  localparam bit WP_ON = 1'b1;
`else
  localparam bit WP_ON = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [ADDR_WIDTH-1:0]   clr_ptr;
  logic [DATA_WIDTH-1:0]   ram [DEPTH];

  logic                    ram_we;
  logic [ADDR_WIDTH-1:0]   ram_waddr;
  logic [DATA_WIDTH-1:0]   ram_wdata;
  logic                    cpu_wr_low;
  logic                    cpu_wr_drop;

  assign cpu_wr_low  = addr < ADDR_WIDTH'(PROG_START);
  // Constant-false when protection is not compiled in.
  assign cpu_wr_drop = (state == S_RUN) && we && WP_ON && cpu_wr_low;

  // Next state, RAM write port select and combinational outputs.
  always_comb begin
    state_next = state;
    ram_we     = 1'b0;
    ram_waddr  = clr_ptr;
    ram_wdata  = '0;
    ld_ready   = 1'b0;
    mem        = '0;
    case (state)
      S_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = clr_ptr;
        // The last word is written on the same edge that leaves S_CLEAR.
        if (&clr_ptr) state_next = S_LOAD;
      end
      S_LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          ram_we    = 1'b1;
          ram_waddr = ld_addr;
          ram_wdata = ld_data;
          if (ld_last) state_next = S_RUN;
        end
      end
      S_RUN: begin
        // Asynchronous read: a write this cycle is seen only next cycle.
        mem = ram[addr];
        if (we && !cpu_wr_drop) begin
          ram_we    = 1'b1;
          ram_waddr = addr;
          ram_wdata = data;
        end
      end
      default: state_next = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_CLEAR;
      clr_ptr <= '0;
      cpu_run <= 1'b0;
      busy    <= 1'b1;
    end else begin
      state <= state_next;
      if (state == S_CLEAR) clr_ptr <= clr_ptr + ADDR_WIDTH'(1);
      // Registered flags follow the state being entered on this edge.
      cpu_run <= (state_next == S_RUN);
      busy    <= (state_next != S_RUN);
    end
  end

  // RAM has no reset of its own; S_CLEAR zero-fills it after every reset.
  always_ff @(posedge clk) begin
    if (!rst && ram_we) ram[ram_waddr] <= ram_wdata;
  end

`ifdef MEM_WP_EN
  always_ff @(posedge clk) begin
    if (rst)              wp_err <= 1'b0;
    else if (cpu_wr_drop) wp_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_cpu_mem_responder.sv
module tb_cpu_mem_responder;

  logic        clk;
  logic        rst;
  logic [5:0]  addr;
  logic [15:0] data;
  logic        we;
  logic [15:0] mem;
  logic        ld_valid;
  logic        ld_ready;
  logic [5:0]  ld_addr;
  logic [15:0] ld_data;
  logic        ld_last;
  logic        cpu_run;
  logic        busy;
`ifdef MEM_WP_EN
  logic        wp_err;
  localparam bit TB_WP = 1'b1;
`else
  localparam bit TB_WP = 1'b0;
`endif

  cpu_mem_responder dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .data     (data),
    .we       (we),
    .mem      (mem),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .ld_last  (ld_last),
    .cpu_run  (cpu_run),
`ifdef MEM_WP_EN
    .busy     (busy),
    .wp_err   (wp_err)
`else
    .busy     (busy)
`endif
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model + scoreboard ----------------
  logic [15:0] ref_ram [64];
  logic        exp_wp;
  logic [15:0] exp_q[$];
  int          total;
  int          bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) ref_ram[i] = 16'h0000;
    exp_wp = 1'b0;
  endtask

  // Monitor: every running cycle the DUT presents a read; pop and compare.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
`ifdef MEM_WP_EN
      check("wp_err", {31'd0, wp_err}, {31'd0, exp_wp});
`endif
      if (cpu_run === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL mem_underflow: read presented with no expectation at %0t", $time);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          check("mem_read", {16'd0, mem}, {16'd0, e});
        end
      end
    end
  end

  // ---------------- driver tasks (all start and end at posedge+1) ----------------
  task automatic reset_dut();
    rst      = 1'b1;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    we       = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
    // 64 clearing cycles: CPU held, loader not yet accepted, reads forced to 0.
    for (int i = 0; i < 64; i++) begin
      addr     = 6'($urandom_range(0, 63));
      we       = 1'($urandom_range(0, 1));
      data     = 16'($urandom);
      ld_valid = 1'($urandom_range(0, 1));
      ld_addr  = 6'($urandom_range(0, 63));
      ld_data  = 16'($urandom);
      @(negedge clk);
      check("clear_status", {29'd0, busy, cpu_run, ld_ready}, 32'b100);
      check("clear_mem", {16'd0, mem}, 32'd0);
      @(posedge clk);
      #1;
    end
    ld_valid = 1'b0;
    we       = 1'b0;
  endtask

  task automatic ld_word(input logic [5:0] a, input logic [15:0] d, input logic last, input int gap);
    for (int g = 0; g < gap; g++) begin
      ld_valid = 1'b0;
      ld_addr  = 6'($urandom_range(0, 63));
      ld_data  = 16'($urandom);
      ld_last  = 1'($urandom_range(0, 1));
      addr     = 6'($urandom_range(0, 63));
      we       = 1'b1;
      data     = 16'($urandom);
      @(negedge clk);
      check("load_idle_status", {29'd0, ld_ready, busy, cpu_run}, 32'b110);
      check("load_idle_mem", {16'd0, mem}, 32'd0);
      @(posedge clk);
      #1;
    end
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    ld_last  = last;
    addr     = 6'($urandom_range(0, 63));
    we       = 1'b1;
    data     = 16'($urandom);
    @(negedge clk);
    check("load_status", {29'd0, ld_ready, busy, cpu_run}, 32'b110);
    check("load_mem", {16'd0, mem}, 32'd0);
    @(posedge clk);
    ref_ram[a] = d;
    #1;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    we       = 1'b0;
  endtask

  task automatic cpu_cycle(input logic [5:0] a, input logic w, input logic [15:0] d);
    addr     = a;
    we       = w;
    data     = d;
    ld_valid = 1'($urandom_range(0, 1));
    ld_addr  = 6'($urandom_range(0, 63));
    ld_data  = 16'($urandom);
    ld_last  = 1'($urandom_range(0, 1));
    exp_q.push_back(ref_ram[a]);
    @(negedge clk);
    check("run_status", {29'd0, cpu_run, busy, ld_ready}, 32'b100);
    @(posedge clk);
    if (w) begin
      if (TB_WP && a < 6'd8) exp_wp = 1'b1;
      else ref_ram[a] = d;
    end
    #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    addr     = '0;
    data     = '0;
    we       = 1'b0;
    ld_valid = 1'b0;
    ld_addr  = '0;
    ld_data  = '0;
    ld_last  = 1'b0;
    model_clear();
    @(posedge clk);
    #1;

    // Reset and clear, then directed load with stalls.
    reset_dut();
    ld_word(6'd8,  16'h1234, 1'b0, 0);
    ld_word(6'd9,  16'h0081, 1'b0, 5);
    ld_word(6'd10, 16'hF000, 1'b1, 5);

    // First running cycle: same-cycle read of the loaded word.
    cpu_cycle(6'd8, 1'b0, 16'h0);
    for (int i = 0; i < 64; i++) cpu_cycle(6'(i), 1'b0, 16'h0);

    // CPU write: old value this cycle, new value next cycle.
    cpu_cycle(6'd20, 1'b1, 16'hBEEF);
    cpu_cycle(6'd20, 1'b0, 16'h0);

    // Write into the protected low region.
    cpu_cycle(6'd3, 1'b1, 16'hAAAA);
    cpu_cycle(6'd3, 1'b0, 16'h0);
    cpu_cycle(6'd7, 1'b0, 16'h0);

    // Random CPU traffic.
    for (int i = 0; i < 150; i++)
      cpu_cycle(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 16'($urandom));

    // Reset mid-load: first two words must not survive.
    reset_dut();
    ld_word(6'd8, 16'h5555, 1'b0, 0);
    ld_word(6'd9, 16'h6666, 1'b0, 1);
    reset_dut();
    ld_word(6'd40, 16'h4040, 1'b1, 2);
    cpu_cycle(6'd8, 1'b0, 16'h0);
    cpu_cycle(6'd9, 1'b0, 16'h0);
    cpu_cycle(6'd40, 1'b0, 16'h0);
    for (int i = 0; i < 40; i++)
      cpu_cycle(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 16'($urandom));

    // Reset mid-run, random image with repeated addresses and gaps.
    reset_dut();
    for (int i = 0; i < 12; i++)
      ld_word(6'($urandom_range(0, 15)), 16'($urandom), 1'b0, $urandom_range(0, 3));
    ld_word(6'($urandom_range(0, 15)), 16'($urandom), 1'b1, 1);
    for (int i = 0; i < 16; i++) cpu_cycle(6'(i), 1'b0, 16'h0);
    for (int i = 0; i < 100; i++)
      cpu_cycle(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 16'($urandom));

    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
